// File: rtl/video_sched_pkg.sv
// Shared types for the vertical-blank write scheduler: the queued bus write
// and the scheduler state encoding.
package video_sched_pkg;

    localparam int ADDR_W         = 21;
    localparam int DATA_W         = 32;
    localparam int FB_BIT_DEFAULT = 20;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } vid_wr_t;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

endpackage

// File: rtl/video_wr_fifo.sv
// First-word-fall-through FIFO of deferred slot-register writes.
module video_wr_fifo
    import video_sched_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset_sys_n,
    input  logic                   push,
    input  logic                   pop,
    input  vid_wr_t                din,
    output vid_wr_t                dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]     CNT_FULL = (PTR_W + 1)'(DEPTH);

    vid_wr_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!do_push_s && do_pop_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/video_vblank_wr_sched.sv
// Defers sprite/OSD/slot register writes to a window after frame_start while
// frame-buffer writes pass straight through with priority on the output bus.
module video_vblank_wr_sched
    import video_sched_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int DRAIN_CYCLES = 1024,
    parameter int FB_BIT       = FB_BIT_DEFAULT
) (
    input  logic                   clk_sys,
    input  logic                   reset_sys_n,
    input  logic                   cpu_cs,
    input  logic                   cpu_wr,
    input  logic [20:0]            cpu_addr,
    input  logic [31:0]            cpu_wr_data,
    input  logic                   frame_start,
    input  logic                   defer_en,
    input  logic                   ovf_clr,
    output logic                   video_cs,
    output logic                   video_wr,
    output logic [20:0]            video_addr,
    output logic [31:0]            video_wr_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   draining,
    output logic                   ovf_flag
);

    localparam int               CNT_W    = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_ONE  = CNT_W'(1);

    sched_state_t     state_r;
    logic [CNT_W-1:0] win_cnt_r;
    logic             req_s;
    logic             bypass_s;
    logic             enq_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    vid_wr_t          fifo_din_s;
    vid_wr_t          fifo_dout_s;

    // Request classification. Once anything is queued, slot writes keep queuing
    // so that they never overtake older slot writes.
    always_comb begin
        req_s      = cpu_cs & cpu_wr;
        bypass_s   = req_s & (cpu_addr[FB_BIT] | (~defer_en & fifo_empty_s));
        enq_s      = req_s & ~bypass_s;
        pop_s      = (state_r != HOLD) & ~fifo_empty_s & ~bypass_s;
        push_s     = enq_s & (~fifo_full_s | pop_s);
        drop_s     = enq_s & fifo_full_s & ~pop_s;
        fifo_din_s = '{addr: cpu_addr, data: cpu_wr_data};
    end

    video_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys     (clk_sys),
        .reset_sys_n (reset_sys_n),
        .push        (push_s),
        .pop         (pop_s),
        .din         (fifo_din_s),
        .dout        (fifo_dout_s),
        .full        (fifo_full_s),
        .empty       (fifo_empty_s),
        .count       (fifo_count)
    );

    // Output bus register: bypass wins, otherwise the popped FIFO head.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            video_cs      <= 1'b0;
            video_wr      <= 1'b0;
            video_addr    <= 21'd0;
            video_wr_data <= 32'd0;
        end else if (bypass_s) begin
            video_cs      <= 1'b1;
            video_wr      <= 1'b1;
            video_addr    <= cpu_addr;
            video_wr_data <= cpu_wr_data;
        end else if (pop_s) begin
            video_cs      <= 1'b1;
            video_wr      <= 1'b1;
            video_addr    <= fifo_dout_s.addr;
            video_wr_data <= fifo_dout_s.data;
        end else begin
            video_cs      <= 1'b0;
            video_wr      <= 1'b0;
            video_addr    <= 21'd0;
            video_wr_data <= 32'd0;
        end
    end

    // Window/flush sequencer; draining is registered alongside the state.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            state_r   <= HOLD;
            win_cnt_r <= '0;
            draining  <= 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    if (frame_start) begin
                        state_r   <= DRAIN;
                        win_cnt_r <= '0;
                        draining  <= 1'b1;
                    end else if (!defer_en && !fifo_empty_s) begin
                        state_r  <= FLUSH;
                        draining <= 1'b1;
                    end else begin
                        state_r  <= HOLD;
                        draining <= 1'b0;
                    end
                end
                DRAIN: begin
                    win_cnt_r <= win_cnt_r + WIN_ONE;
                    if (!defer_en) begin
                        state_r  <= FLUSH;
                        draining <= 1'b1;
                    end else if (frame_start) begin
                        state_r   <= DRAIN;
                        win_cnt_r <= '0;
                        draining  <= 1'b1;
                    end else if ((win_cnt_r == WIN_LAST) || (fifo_empty_s && !push_s)) begin
                        state_r  <= HOLD;
                        draining <= 1'b0;
                    end else begin
                        state_r  <= DRAIN;
                        draining <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (fifo_empty_s) begin
                        state_r  <= HOLD;
                        draining <= 1'b0;
                    end else begin
                        state_r  <= FLUSH;
                        draining <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= HOLD;
                    draining <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write outranks a same-cycle clear.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            ovf_flag <= 1'b0;
        end else if (drop_s) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end else begin
            ovf_flag <= ovf_flag;
        end
    end

endmodule

// File: tb/tb_video_vblank_wr_sched.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 a 4-cycle drain window.
`timescale 1ns/1ps
module tb_video_vblank_wr_sched;
    import video_sched_pkg::*;

    typedef struct {
        logic [20:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk_sys     = 1'b0;
    logic        reset_sys_n = 1'b0;
    logic        cpu_cs      [2];
    logic        cpu_wr      [2];
    logic [20:0] cpu_addr    [2];
    logic [31:0] cpu_wr_data [2];
    logic        frame_start [2];
    logic        defer_en    [2];
    logic        ovf_clr     [2];
    logic        video_cs    [2];
    logic        video_wr    [2];
    logic [20:0] video_addr  [2];
    logic [31:0] video_wr_data [2];
    logic [4:0]  fifo_count  [2];
    logic        draining    [2];
    logic        ovf_flag    [2];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];

    video_vblank_wr_sched dut_a (
        .clk_sys(clk_sys), .reset_sys_n(reset_sys_n),
        .cpu_cs(cpu_cs[0]), .cpu_wr(cpu_wr[0]), .cpu_addr(cpu_addr[0]), .cpu_wr_data(cpu_wr_data[0]),
        .frame_start(frame_start[0]), .defer_en(defer_en[0]), .ovf_clr(ovf_clr[0]),
        .video_cs(video_cs[0]), .video_wr(video_wr[0]), .video_addr(video_addr[0]),
        .video_wr_data(video_wr_data[0]), .fifo_count(fifo_count[0]),
        .draining(draining[0]), .ovf_flag(ovf_flag[0])
    );

    video_vblank_wr_sched #(.DRAIN_CYCLES(4)) dut_b (
        .clk_sys(clk_sys), .reset_sys_n(reset_sys_n),
        .cpu_cs(cpu_cs[1]), .cpu_wr(cpu_wr[1]), .cpu_addr(cpu_addr[1]), .cpu_wr_data(cpu_wr_data[1]),
        .frame_start(frame_start[1]), .defer_en(defer_en[1]), .ovf_clr(ovf_clr[1]),
        .video_cs(video_cs[1]), .video_wr(video_wr[1]), .video_addr(video_addr[1]),
        .video_wr_data(video_wr_data[1]), .fifo_count(fifo_count[1]),
        .draining(draining[1]), .ovf_flag(ovf_flag[1])
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int k, input logic [20:0] a, input logic [31:0] d, input int due);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.due  = due;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_check(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out dut%0d: addr=0x%0h data=0x%0h (cycle %0d), expected no output",
                     k, video_addr[k], video_wr_data[k], cyc);
        end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("out_wr dut%0d", k), {31'd0, video_wr[k]}, 32'd1);
            check($sformatf("out_addr dut%0d", k), {11'd0, video_addr[k]}, {11'd0, e.addr});
            check($sformatf("out_data dut%0d", k), video_wr_data[k], e.data);
            if (e.due >= 0) check($sformatf("out_cycle dut%0d", k), cyc, e.due);
        end
    endtask

    // Monitor: every bus write presented by either instance is matched against its queue.
    always @(negedge clk_sys) begin
        for (int k = 0; k < 2; k++) begin
            if (video_cs[k] || video_wr[k]) mon_check(k);
        end
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wr(input int k, input logic [20:0] a, input logic [31:0] d);
        cpu_cs[k] = 1'b1; cpu_wr[k] = 1'b1; cpu_addr[k] = a; cpu_wr_data[k] = d;
        tick();
        cpu_cs[k] = 1'b0; cpu_wr[k] = 1'b0;
    endtask

    task automatic pulse_frame(input int k);
        frame_start[k] = 1'b1;
        tick();
        frame_start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while (draining[k] && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("drain_timeout dut%0d", k), {31'd0, draining[k]}, 32'd0);
    endtask

    initial begin
        int c;
        int n;
        for (int k = 0; k < 2; k++) begin
            cpu_cs[k] = 1'b0; cpu_wr[k] = 1'b0; cpu_addr[k] = 21'd0; cpu_wr_data[k] = 32'd0;
            frame_start[k] = 1'b0; defer_en[k] = 1'b1; ovf_clr[k] = 1'b0;
        end
        repeat (3) tick();
        check("rst_cs", {31'd0, video_cs[0]}, 32'd0);
        check("rst_count", {27'd0, fifo_count[0]}, 32'd0);
        check("rst_draining", {31'd0, draining[0]}, 32'd0);
        check("rst_ovf", {31'd0, ovf_flag[0]}, 32'd0);
        reset_sys_n = 1'b1;
        tick();

        // Frame-buffer write bypasses in HOLD with 1-cycle latency.
        push_exp(0, 21'h100040, 32'hABC, cyc + 1);
        wr(0, 21'h100040, 32'hABC);
        tick();
        check("fb_count", {27'd0, fifo_count[0]}, 32'd0);

        // Three deferred slot writes drain on consecutive cycles after frame_start.
        for (int i = 0; i < 3; i++) wr(0, 21'h00800 + 21'(i), 32'(i + 1));
        check("defer_count3", {27'd0, fifo_count[0]}, 32'd3);
        c = cyc;
        for (int i = 0; i < 3; i++) push_exp(0, 21'h00800 + 21'(i), 32'(i + 1), c + 2 + i);
        pulse_frame(0);
        check("draining_high", {31'd0, draining[0]}, 32'd1);
        wait_idle(0, 10);
        check("drain3_cycle", cyc, c + 5);
        check("drain3_count", {27'd0, fifo_count[0]}, 32'd0);

        // Frame-buffer write injected in the 2nd drain cycle takes that output slot.
        for (int i = 0; i < 4; i++) wr(0, 21'h00810 + 21'(i), 32'h10 + 32'(i));
        c = cyc;
        push_exp(0, 21'h00810, 32'h10, c + 2);
        pulse_frame(0);
        tick();
        push_exp(0, 21'h100077, 32'hF00D, c + 3);
        wr(0, 21'h100077, 32'hF00D);
        for (int i = 1; i < 4; i++) push_exp(0, 21'h00810 + 21'(i), 32'h10 + 32'(i), c + 3 + i);
        wait_idle(0, 12);
        check("inject_count", {27'd0, fifo_count[0]}, 32'd0);
        check("inject_q_empty", q0.size(), 32'd0);

        // Overflow: 17 writes into a 16-deep FIFO, then push+pop at full.
        for (int i = 0; i < 17; i++) wr(0, 21'h00900 + 21'(i), 32'h100 + 32'(i));
        check("full_count", {27'd0, fifo_count[0]}, 32'd16);
        check("ovf_set", {31'd0, ovf_flag[0]}, 32'd1);
        for (int i = 0; i < 16; i++) push_exp(0, 21'h00900 + 21'(i), 32'h100 + 32'(i), -1);
        push_exp(0, 21'h00A00, 32'h5A5, -1);
        pulse_frame(0);
        wr(0, 21'h00A00, 32'h5A5);
        check("full_pushpop_count", {27'd0, fifo_count[0]}, 32'd16);
        check("ovf_sticky", {31'd0, ovf_flag[0]}, 32'd1);
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr[0] = 1'b0;
        check("ovf_cleared", {31'd0, ovf_flag[0]}, 32'd0);
        wait_idle(0, 40);
        check("ovf_q_empty", q0.size(), 32'd0);

        // Short window (4 cycles): 10 queued, 4 drained, then flush the remaining 6.
        for (int i = 0; i < 10; i++) wr(1, 21'h00C00 + 21'(i), 32'h200 + 32'(i));
        check("win_count10", {27'd0, fifo_count[1]}, 32'd10);
        c = cyc;
        for (int i = 0; i < 4; i++) push_exp(1, 21'h00C00 + 21'(i), 32'h200 + 32'(i), c + 2 + i);
        pulse_frame(1);
        wait_idle(1, 12);
        check("win_hold_cycle", cyc, c + 5);
        repeat (3) tick();
        check("win_count6", {27'd0, fifo_count[1]}, 32'd6);
        for (int i = 4; i < 10; i++) push_exp(1, 21'h00C00 + 21'(i), 32'h200 + 32'(i), -1);
        defer_en[1] = 1'b0;
        tick();
        check("flush_draining", {31'd0, draining[1]}, 32'd1);
        wait_idle(1, 12);
        check("flush_count", {27'd0, fifo_count[1]}, 32'd0);
        push_exp(1, 21'h00C55, 32'h777, cyc + 1);
        wr(1, 21'h00C55, 32'h777);
        tick();
        check("flush_bypass_count", {27'd0, fifo_count[1]}, 32'd0);
        check("win_q_empty", q1.size(), 32'd0);

        // Asynchronous reset mid-drain with 5 entries still queued.
        for (int i = 0; i < 7; i++) wr(0, 21'h00D00 + 21'(i), 32'h300 + 32'(i));
        push_exp(0, 21'h00D00, 32'h300, -1);
        push_exp(0, 21'h00D01, 32'h301, -1);
        pulse_frame(0);
        n = 0;
        while (fifo_count[0] != 5'd5 && n < 10) begin
            tick();
            n++;
        end
        check("pre_reset_count", {27'd0, fifo_count[0]}, 32'd5);
        #1 reset_sys_n = 1'b0;
        #1;
        check("async_rst_cs", {31'd0, video_cs[0]}, 32'd0);
        check("async_rst_addr", {11'd0, video_addr[0]}, 32'd0);
        check("async_rst_count", {27'd0, fifo_count[0]}, 32'd0);
        check("async_rst_draining", {31'd0, draining[0]}, 32'd0);
        repeat (2) tick();
        reset_sys_n = 1'b1;
        tick();
        pulse_frame(0);
        repeat (6) tick();
        check("post_reset_count", {27'd0, fifo_count[0]}, 32'd0);
        check("post_reset_draining", {31'd0, draining[0]}, 32'd0);
        check("final_q0_empty", q0.size(), 32'd0);
        check("final_q1_empty", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
